// File: rtl/ram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ram_rr_arbiter
//
// Shares one single-port parity RAM between two requesters. Each accepted
// request is turned into a one-cycle RAM access. Reads return data through a
// shared rdata bus, with a per-requester valid pulse. Arbitration is
// round-robin. The pointer moves to the other requester whenever a
// transaction finishes, so two requesters that hold req high alternate
// 0,1,0,1.
//
// Optional feature:
//   RAM_ARB_PARITY_CHK_EN - when defined, adds the perr / perr_cnt outputs.
//   The parity bit of each read word is checked in CAPTURE. perr pulses with
//   rvalid, and perr_cnt saturates at 255. When the macro is undefined, the
//   parity bit of ram_data_out is ignored.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req0/req1         request, held high until granted
//   we0/we1           1 = write, 0 = read (valid while reqN high)
//   addr0/addr1       request address (AW bits)
//   wdata0/wdata1     write data (DW bits)
//   gnt0/gnt1         one-cycle pulse: request accepted and latched
//   rvalid0/rvalid1   one-cycle pulse: rdata holds this requester's result
//   rdata             read data, shared by both requesters
//   busy              high whenever the sequencer is not in IDLE
//   ram_write         RAM write strobe
//   ram_read          RAM read strobe
//   ram_address       RAM address
//   ram_data_in       RAM write data
//   ram_data_out      RAM read word {parity, data}, valid the cycle after
//                     ram_read
//   perr, perr_cnt    parity error pulse / saturating count (optional)
//
// Timing, counted from the edge that samples req in IDLE:
//   write: gnt + ram_write in cycle +1, back in IDLE after 2 cycles
//   read : gnt + ram_read in cycle +1, rvalid in cycle +3, 3 cycles total
// ---------------------------------------------------------------------------
module ram_rr_arbiter #(
  parameter int AW = 19,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_write,
  output logic          ram_read,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW:0]   ram_data_out
`ifdef RAM_ARB_PARITY_CHK_EN
  ,
  output logic          perr,
  output logic [7:0]    perr_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            ptr_reg, ptr_next;          // requester favoured on a tie
  logic            owner_reg, owner_next;      // requester being served
  logic            op_we_reg, op_we_next;      // latched write/read flag
  logic [1:0]      gnt_reg, gnt_next;
  logic [1:0]      rvalid_reg, rvalid_next;
  logic [DW-1:0]   rdata_reg, rdata_next;
  logic            busy_reg, busy_next;
  logic            ram_write_reg, ram_write_next;
  logic            ram_read_reg, ram_read_next;
  logic [AW-1:0]   ram_address_reg, ram_address_next;
  logic [DW-1:0]   ram_data_in_reg, ram_data_in_next;

  // Arbitration: a sole requester always wins. On a tie, the pointer decides.
  logic            any_req;
  logic            winner;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;

  assign any_req   = req0 | req1;
  assign winner    = (req0 & req1) ? ptr_reg : req1;
  assign win_we    = winner ? we1 : we0;
  assign win_addr  = winner ? addr1 : addr0;
  assign win_wdata = winner ? wdata1 : wdata0;

`ifdef RAM_ARB_PARITY_CHK_EN
  logic            perr_reg, perr_next;
  logic [7:0]      perr_cnt_reg, perr_cnt_next;
  logic            parity_bad;

  // The stored parity bit must equal the XOR of the data bits.
  assign parity_bad = ram_data_out[DW] != (^ram_data_out[DW-1:0]);
`else
  // Without the checker, the parity bit of the RAM word is not used.
  logic            unused_parity_bit;
  assign unused_parity_bit = ram_data_out[DW];
`endif

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    owner_next       = owner_reg;
    op_we_next       = op_we_reg;
    gnt_next         = 2'b00;
    rvalid_next      = 2'b00;
    rdata_next       = rdata_reg;
    ram_write_next   = 1'b0;
    ram_read_next    = 1'b0;
    ram_address_next = ram_address_reg;
    ram_data_in_next = ram_data_in_reg;
`ifdef RAM_ARB_PARITY_CHK_EN
    perr_next        = 1'b0;
    perr_cnt_next    = perr_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          owner_next         = winner;
          op_we_next         = win_we;
          gnt_next[winner]   = 1'b1;
          // The RAM outputs are registered. Loading them here puts the
          // strobe on the RAM during the ACCESS cycle, alongside gnt.
          ram_address_next   = win_addr;
          ram_write_next     = win_we;
          ram_read_next      = ~win_we;
          if (win_we) begin
            ram_data_in_next = win_wdata;
          end
          state_next         = ACCESS;
        end
      end

      ACCESS: begin
        if (op_we_reg) begin
          // The write is done once this cycle ends.
          ptr_next   = ~owner_reg;
          state_next = IDLE;
        end else begin
          state_next = CAPTURE;
        end
      end

      CAPTURE: begin
        // ram_data_out now carries the word addressed during ACCESS.
        rdata_next             = ram_data_out[DW-1:0];
        rvalid_next[owner_reg] = 1'b1;
        ptr_next               = ~owner_reg;
        state_next             = IDLE;
`ifdef RAM_ARB_PARITY_CHK_EN
        if (parity_bad) begin
          perr_next = 1'b1;
          if (perr_cnt_reg != 8'hFF) begin
            perr_cnt_next = perr_cnt_reg + 8'd1;
          end
        end
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // -------------------------------------------------------------------------
  // State and output registers. An asynchronous reset aborts any transaction
  // in flight, and the RAM strobes drop at once.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      ptr_reg         <= 1'b0;
      owner_reg       <= 1'b0;
      op_we_reg       <= 1'b0;
      gnt_reg         <= 2'b00;
      rvalid_reg      <= 2'b00;
      rdata_reg       <= '0;
      busy_reg        <= 1'b0;
      ram_write_reg   <= 1'b0;
      ram_read_reg    <= 1'b0;
      ram_address_reg <= '0;
      ram_data_in_reg <= '0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      owner_reg       <= owner_next;
      op_we_reg       <= op_we_next;
      gnt_reg         <= gnt_next;
      rvalid_reg      <= rvalid_next;
      rdata_reg       <= rdata_next;
      busy_reg        <= busy_next;
      ram_write_reg   <= ram_write_next;
      ram_read_reg    <= ram_read_next;
      ram_address_reg <= ram_address_next;
      ram_data_in_reg <= ram_data_in_next;
    end
  end

`ifdef RAM_ARB_PARITY_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_reg     <= 1'b0;
      perr_cnt_reg <= 8'd0;
    end else begin
      perr_reg     <= perr_next;
      perr_cnt_reg <= perr_cnt_next;
    end
  end

  assign perr     = perr_reg;
  assign perr_cnt = perr_cnt_reg;
`endif

  assign gnt0        = gnt_reg[0];
  assign gnt1        = gnt_reg[1];
  assign rvalid0     = rvalid_reg[0];
  assign rvalid1     = rvalid_reg[1];
  assign rdata       = rdata_reg;
  assign busy        = busy_reg;
  assign ram_write   = ram_write_reg;
  assign ram_read    = ram_read_reg;
  assign ram_address = ram_address_reg;
  assign ram_data_in = ram_data_in_reg;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for ram_rr_arbiter. A behavioural parity RAM with a registered
// read is attached to the arbiter's RAM port. Expected read data comes from a
// shadow memory that the bench updates whenever it issues a write. Each
// expected value is queued when the read is issued, and is popped when the
// matching rvalid is seen.
// ---------------------------------------------------------------------------
module tb_ram_rr_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_write, ram_read;
  logic [DW-1:0] rdata, ram_data_in;
  logic [AW-1:0] ram_address;
  logic [DW:0]   ram_data_out = '0;
`ifdef RAM_ARB_PARITY_CHK_EN
  logic          perr;
  logic [7:0]    perr_cnt;
`endif

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] exp_mem [int];
  logic          flip_parity = 1'b0;

  always #5 clk = ~clk;

  ram_rr_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .ram_write(ram_write), .ram_read(ram_read),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
`ifdef RAM_ARB_PARITY_CHK_EN
    , .perr(perr), .perr_cnt(perr_cnt)
`endif
  );

  // Background contents of every RAM location that was never written.
  function automatic logic [7:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [AW-1:0] a);
    if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
    return init_val(a);
  endfunction

  // Parity RAM model. The read is registered, and flip_parity corrupts the
  // parity bit of the word that is returned.
  logic [DW:0] ram_mem [0:DEPTH-1];
  bit          ram_written [0:DEPTH-1];

  always @(posedge clk) begin
    if (ram_write) begin
      ram_mem[ram_address]     <= {^ram_data_in, ram_data_in};
      ram_written[ram_address] <= 1'b1;
    end
    if (ram_read) begin
      if (ram_written[ram_address])
        ram_data_out <= {ram_mem[ram_address][DW] ^ flip_parity, ram_mem[ram_address][DW-1:0]};
      else
        ram_data_out <= {(^init_val(ram_address)) ^ flip_parity, init_val(ram_address)};
    end
  end

  // Scoreboard side: every rvalid pops its requester's queue. The monitor
  // also checks that the two RAM strobes are never high together.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid0) begin
        vectors++;
        if (q0.size() == 0) begin
          miscompares++;
          $display("FAIL rvalid0_unexpected: got rvalid0=1 rdata=%h, want no pulse", rdata);
        end else begin
          logic [DW-1:0] e0;
          e0 = q0.pop_front();
          $display("rd req0 rdata=%h exp=%h", rdata, e0);
          if (rdata !== e0) begin
            miscompares++;
            $display("FAIL rdata_req0: got %h, want %h", rdata, e0);
          end
        end
      end
      if (rvalid1) begin
        vectors++;
        if (q1.size() == 0) begin
          miscompares++;
          $display("FAIL rvalid1_unexpected: got rvalid1=1 rdata=%h, want no pulse", rdata);
        end else begin
          logic [DW-1:0] e1;
          e1 = q1.pop_front();
          $display("rd req1 rdata=%h exp=%h", rdata, e1);
          if (rdata !== e1) begin
            miscompares++;
            $display("FAIL rdata_req1: got %h, want %h", rdata, e1);
          end
        end
      end
      if (ram_write || ram_read) begin
        vectors++;
        if (ram_write && ram_read) begin
          miscompares++;
          $display("FAIL strobes_exclusive: got write=1 read=1, want at most one");
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_write(input bit who, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    exp_mem[int'(a)] = d;
    if (who) begin req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d; end
    else     begin req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (who ? gnt1 : gnt0) got = 1'b1;
    end
    if (who) req1 = 1'b0; else req0 = 1'b0;
    $display("wr req%0d addr=%h data=%h", who, a, d);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL write_grant: got no gnt%0d in 8 cycles, want gnt", who);
    end
  endtask

  task automatic do_read(input bit who, input logic [AW-1:0] a);
    bit got;
    got = 1'b0;
    if (who) begin q1.push_back(exp_rd(a)); req1 = 1'b1; we1 = 1'b0; addr1 = a; end
    else     begin q0.push_back(exp_rd(a)); req0 = 1'b1; we0 = 1'b0; addr0 = a; end
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (who ? gnt1 : gnt0) got = 1'b1;
    end
    if (who) req1 = 1'b0; else req0 = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL read_grant: got no gnt%0d in 8 cycles, want gnt", who);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({gnt1, gnt0, rvalid1, rvalid0} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: got %b, want 0000", {gnt1, gnt0, rvalid1, rvalid0});
    end
    vectors++;
    if ({busy, ram_write, ram_read} !== 3'b0) begin
      miscompares++;
      $display("FAIL reset_busy_strobes: got %b, want 000", {busy, ram_write, ram_read});
    end
    vectors++;
    if (ram_address !== '0) begin
      miscompares++;
      $display("FAIL reset_address: got %h, want 0", ram_address);
    end
    vectors++;
    if ({ram_data_in, rdata} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h, want 0000", {ram_data_in, rdata});
    end
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 19'h0_1234; wdata0 = 8'hA5;
    exp_mem[int'(19'h0_1234)] = 8'hA5;
    tick();
    vectors++;
    if ({gnt1, gnt0, ram_write, ram_read, busy} !== 5'b01101 ||
        ram_address !== 19'h0_1234 || ram_data_in !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_write: got gnt=%b wr=%b rd=%b busy=%b addr=%h din=%h, want gnt=01 wr=1 rd=0 busy=1 addr=01234 din=a5",
               {gnt1, gnt0}, ram_write, ram_read, busy, ram_address, ram_data_in);
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if ({gnt0, ram_write, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL write_done: got gnt0/wr/busy=%b, want 000", {gnt0, ram_write, busy});
    end
    $display("wr req0 addr=01234 data=a5");
    req0 = 1'b1; we0 = 1'b0; addr0 = 19'h0_1234;
    q0.push_back(exp_rd(19'h0_1234));
    tick();
    vectors++;
    if ({gnt0, ram_read, ram_write} !== 3'b110 || ram_address !== 19'h0_1234) begin
      miscompares++;
      $display("FAIL read_access: got gnt0/rd/wr=%b addr=%h, want 110 addr=01234",
               {gnt0, ram_read, ram_write}, ram_address);
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if ({rvalid0, ram_read, busy} !== 3'b001) begin
      miscompares++;
      $display("FAIL read_capture: got rvalid0/rd/busy=%b, want 001", {rvalid0, ram_read, busy});
    end
    tick();
    vectors++;
    if (rvalid0 !== 1'b1 || rdata !== 8'hA5 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL read_result: got rvalid0=%b rdata=%h busy=%b, want 1 a5 0", rvalid0, rdata, busy);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    int   ngr;
    logic exp_owner;
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 19'h100; wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 19'h200; wdata1 = 8'h22;
    exp_mem[int'(19'h100)] = 8'h11;
    exp_mem[int'(19'h200)] = 8'h22;
    tick();
    vectors++;
    if ({gnt1, gnt0} !== 2'b01 || ram_address !== 19'h100) begin
      miscompares++;
      $display("FAIL tie_first: got gnt=%b addr=%h, want 01 00100", {gnt1, gnt0}, ram_address);
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if ({gnt1, gnt0} !== 2'b00) begin
      miscompares++;
      $display("FAIL tie_gap: got gnt=%b, want 00", {gnt1, gnt0});
    end
    tick();
    vectors++;
    if ({gnt1, gnt0} !== 2'b10 || ram_address !== 19'h200 || ram_data_in !== 8'h22) begin
      miscompares++;
      $display("FAIL tie_second: got gnt=%b addr=%h din=%h, want 10 00200 22",
               {gnt1, gnt0}, ram_address, ram_data_in);
    end
    req1 = 1'b0;
    tick();
    // Both held continuously: grants must alternate, starting with 0.
    req0 = 1'b1; addr0 = 19'h300; wdata0 = 8'h33;
    req1 = 1'b1; addr1 = 19'h400; wdata1 = 8'h44;
    exp_mem[int'(19'h300)] = 8'h33;
    exp_mem[int'(19'h400)] = 8'h44;
    ngr = 0;
    exp_owner = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (gnt0 || gnt1) begin
        $display("gnt cycle=%0d gnt=%b", i, {gnt1, gnt0});
        vectors++;
        if ({gnt1, gnt0} !== (exp_owner ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("FAIL alternate: got gnt=%b, want owner %0d", {gnt1, gnt0}, exp_owner);
        end
        exp_owner = ~exp_owner;
        ngr++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    vectors++;
    if (ngr != 8) begin
      miscompares++;
      $display("FAIL alternate_count: got %0d grants, want 8", ngr);
    end
    tick(); tick();
  endtask

  task automatic test_mixed();
    int n0, n1;
    n0 = 0; n1 = 0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 19'h7FFFF;
    q1.push_back(exp_rd(19'h7FFFF));
    req0 = 1'b1; we0 = 1'b1; addr0 = 19'h00000; wdata0 = 8'h3C;
    exp_mem[0] = 8'h3C;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      if (rvalid0) n0++;
      if (rvalid1) n1++;
    end
    req0 = 1'b0; req1 = 1'b0;
    vectors++;
    if (n0 != 0 || n1 != 1) begin
      miscompares++;
      $display("FAIL mixed_pulses: got rvalid0 x%0d rvalid1 x%0d, want 0 and 1", n0, n1);
    end
    do_read(1'b0, 19'h00000);
  endtask

  task automatic test_reset_mid_read();
    do_write(1'b0, 19'h10, 8'h77);   // pointer now favours requester 1
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 19'h10;
    tick();
    vectors++;
    if (gnt0 !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_gnt: got gnt0=%b, want 1", gnt0);
    end
    req0 = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b1 || ram_read !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_capture: got busy=%b rd=%b, want 1 0", busy, ram_read);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, ram_read, ram_write, rvalid0, rvalid1} !== 5'b0) begin
      miscompares++;
      $display("FAIL abort_async: got busy/rd/wr/rv0/rv1=%b, want 00000",
               {busy, ram_read, ram_write, rvalid0, rvalid1});
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({rvalid0, rvalid1, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_no_rvalid: got rv0/rv1/busy=%b, want 000", {rvalid0, rvalid1, busy});
    end
    req0 = 1'b1; we0 = 1'b1; addr0 = 19'h20; wdata0 = 8'h88;
    req1 = 1'b1; we1 = 1'b1; addr1 = 19'h30; wdata1 = 8'h99;
    exp_mem[int'(19'h20)] = 8'h88;
    exp_mem[int'(19'h30)] = 8'h99;
    tick();
    vectors++;
    if ({gnt1, gnt0} !== 2'b01) begin
      miscompares++;
      $display("FAIL abort_pointer: got gnt=%b, want 01", {gnt1, gnt0});
    end
    req0 = 1'b0;
    tick(); tick();
    vectors++;
    if ({gnt1, gnt0} !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_second: got gnt=%b, want 10", {gnt1, gnt0});
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] al [100];
    int idx, nv, last, cyc;
    for (int i = 0; i < 100; i++) begin
      al[i] = AW'($urandom());
      do_write(1'b0, al[i], DW'($urandom()));
    end
    tick();
    idx = 0; nv = 0; last = -1; cyc = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = al[0];
    q0.push_back(exp_rd(al[0]));
    while (cyc < 400 && nv < 100) begin
      tick();
      cyc++;
      if (gnt0) begin
        idx++;
        if (idx < 100) begin
          addr0 = al[idx];
          q0.push_back(exp_rd(al[idx]));
        end else begin
          req0 = 1'b0;
        end
      end
      if (rvalid0) begin
        if (last >= 0) begin
          vectors++;
          if (cyc - last != 3) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles, want 3", cyc - last);
          end
        end
        last = cyc;
        nv++;
      end
    end
    req0 = 1'b0;
    vectors++;
    if (nv != 100) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d rvalid0 pulses, want 100", nv);
    end
    tick(); tick(); tick();
  endtask

`ifdef RAM_ARB_PARITY_CHK_EN
  task automatic test_parity();
    int nv, cyc;
    do_reset();
    do_write(1'b0, 19'h55, 8'hA5);
    tick();
    flip_parity = 1'b1;              // RAM now returns 9'h1A5
    req0 = 1'b1; we0 = 1'b0; addr0 = 19'h55;
    q0.push_back(8'hA5);
    tick();
    req0 = 1'b0;
    tick(); tick();
    vectors++;
    if ({perr, rvalid0} !== 2'b11 || perr_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL perr_first: got perr=%b rvalid0=%b cnt=%0d, want 1 1 1", perr, rvalid0, perr_cnt);
    end
    tick();
    // 299 more bad reads, for 300 in total, which must saturate the count.
    nv = 0; cyc = 0;
    req0 = 1'b1;
    q0.push_back(8'hA5);
    while (cyc < 1200 && nv < 299) begin
      tick();
      cyc++;
      if (gnt0) begin
        if (nv + 1 < 299 && q0.size() < 2) q0.push_back(8'hA5);
      end
      if (rvalid0) begin
        nv++;
        if (nv >= 298) req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    tick(); tick(); tick(); tick();
    vectors++;
    if (perr_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL perr_saturate: got %0d, want 255", perr_cnt);
    end
    flip_parity = 1'b0;
    q0.delete();
    do_read(1'b0, 19'h55);
    vectors++;
    if (perr !== 1'b0 || perr_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL perr_clean: got perr=%b cnt=%0d, want 0 255", perr, perr_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_mixed();
    test_reset_mid_read();
    test_back_to_back();
`ifdef RAM_ARB_PARITY_CHK_EN
    test_parity();
`endif
    tick(); tick();
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL pending_reads: got %0d/%0d outstanding, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Shares the single-port parity RAM (8-bit write data, 19-bit address, 9-bit read word {parity, data}) between two requesters.
- Round-robin arbitration; sequences each granted transaction onto the RAM strobes; returns read data with a per-requester valid pulse.
- Sits between the two client blocks and the RAM instance; only this block drives the RAM's write/read/address/data_in.

Parameters:
- AW, 19, RAM address width
- DW, 8, RAM data width (RAM word is DW+1 bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request from requester 0 / 1; held high until granted
- we0 / we1  in  1  1 = write, 0 = read; valid while reqN high
- addr0 / addr1  in  AW  request address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted and latched
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata holds this requester's read result
- rdata  out  DW  read data, shared by both requesters
- busy  out  1  high whenever state != IDLE
- ram_write  out  1  to RAM write
- ram_read  out  1  to RAM read
- ram_address  out  AW  to RAM address
- ram_data_in  out  DW  to RAM data_in
- ram_data_out  in  DW+1  from RAM data_out; valid the cycle after ram_read is high

Behaviour:
- All outputs are registered.
- Reset values: all 0, state IDLE, priority pointer = requester 0.
- Reset asserted mid-transaction aborts it: no gnt or rvalid for the aborted request, and RAM strobes drop immediately.
- State IDLE, no req: stay; all strobes 0.
- State IDLE, one or both req:
  - Winner is the sole requester, or the one named by the pointer if both request.
  - Latch we/addr/wdata and owner.
  - Next cycle: gntN = 1 and state ACCESS.
- State ACCESS (one cycle): ram_address = latched addr.
  - Write: ram_write = 1, ram_data_in = latched wdata, then IDLE.
  - Read: ram_read = 1, then CAPTURE.
  - ram_write and ram_read are never both high.
- State CAPTURE (one cycle): sample ram_data_out; next cycle rdata = ram_data_out[DW-1:0] and rvalid(owner) = 1; state IDLE.
- Latency, from the edge that samples req in IDLE:
  - Write: gnt and ram_write in the next cycle; 2 cycles per write.
  - Read: gnt and ram_read in cycle +1, rvalid in cycle +3; 3 cycles per read.
- Pointer flips to the non-owner when a transaction completes, i.e. on leaving ACCESS (write) or CAPTURE (read).
  - Both requesters held high therefore alternate 0,1,0,1.
- Requests arriving while busy are not sampled until IDLE.
  - A requester must keep req high until its gnt.
  - After gnt, req may drop, or stay high to queue its next request, which is arbitrated at the next IDLE.
- ram_address and ram_data_in hold their last value outside ACCESS. rdata holds until the next read completes.
- Address covers the full 2^AW range; no wrap or bounds logic.

Optional Feature:
- Macro RAM_ARB_PARITY_CHK_EN.
- Defined: adds outputs perr (1) and perr_cnt (8).
  - In CAPTURE, checks ram_data_out[DW] == ^ram_data_out[DW-1:0].
  - On mismatch, perr pulses together with rvalid, and perr_cnt increments, saturating at 255.
  - Both outputs reset to 0.
- Undefined: the ports do not exist, and ram_data_out[DW] is ignored.

Test Plan:
- Single write, then read back:
  - req0 we0=1 addr0=19'h0_1234 wdata0=8'hA5 -> gnt0 1 cycle later, ram_write=1 with ram_address=19'h01234, ram_data_in=8'hA5.
  - Then a read of the same address -> rvalid0 3 cycles after sampling, rdata=8'hA5.
- Simultaneous requests after reset:
  - req0 and req1 both writing -> gnt0 first, gnt1 2 cycles later.
  - Both held continuously -> grants alternate 0,1,0,1 with no cycle where both RAM strobes are high.
- Mixed traffic: req1 read of 19'h7FFFF while req0 writes 8'h3C to 19'h00000 -> rvalid1 only, never rvalid0; rdata equals the RAM contents at 19'h7FFFF.
- Reset mid-read: assert rst in CAPTURE -> rvalid0/1 stay 0, busy=0 immediately, pointer=0.
  - After release, a both-request case grants requester 0 first.
- Back-to-back reads by one requester: req0 held for 100 random reads -> 100 rvalid0 pulses, each 3 cycles apart, with data matching a prior random write set.
- With RAM_ARB_PARITY_CHK_EN defined: RAM model returns 9'h1A5 (bad parity) -> perr pulses with rvalid and perr_cnt=1.
  - 300 bad reads -> perr_cnt=255.
